// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: control-bit positions, MEM-stage FSM states
// and the operation codes that steer the MEM/WB output bundle register.
package cpu_pkg;

    localparam int DATA_W = 32;

    // WB control bit positions
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;

    // M control bit positions
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // What the output bundle register does at the next edge
    typedef enum logic [1:0] {
        OUT_PASS,    // load WB/ALU/RegDst and the supplied read data
        OUT_FAULT,   // load ALU/RegDst, squash WB, clear read data, flag error
        OUT_BUBBLE,  // squash WB only
        OUT_ABORT    // squash WB, clear read data, flag error
    } out_op_t;

    // Exactly one of MemRead/MemWrite selects a memory access
    function automatic logic is_access(input logic [1:0] m);
        return m[MEMREAD] ^ m[MEMWRITE];
    endfunction

    // Both control bits set, or a word access that is not word aligned
    function automatic logic is_illegal(input logic [1:0] m, input logic [1:0] addr_lo);
        return (m == 2'b11) || (is_access(m) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and its memory.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = cpu_pkg::DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_out_reg.sv
// MEM/WB-side output bundle register; one op code per cycle decides whether
// the bundle loads, becomes a bubble, or reports a fault.
module mem_wb_out_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  out_op_t           op_i,
    input  logic [1:0]        WB_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [4:0]        RegDst_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [1:0]        WB_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [DATA_W-1:0] ALUresult_o,
    output logic [4:0]        RegDst_o,
    output logic              err_o
);

    logic [1:0]        wb_d,     wb_q;
    logic [DATA_W-1:0] rdata_d,  rdata_q;
    logic [DATA_W-1:0] alu_d,    alu_q;
    logic [4:0]        regdst_d, regdst_q;
    logic              err_d,    err_q;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        wb_d     = wb_q;
        rdata_d  = rdata_q;
        alu_d    = alu_q;
        regdst_d = regdst_q;
        err_d    = 1'b0;

        unique case (op_i)
            OUT_PASS: begin
                wb_d     = WB_i;
                rdata_d  = rdata_i;
                alu_d    = ALUresult_i;
                regdst_d = RegDst_i;
            end
            OUT_FAULT: begin
                wb_d[REGWRITE] = 1'b0;
                wb_d[MEMTOREG] = 1'b0;
                rdata_d        = '0;
                alu_d          = ALUresult_i;
                regdst_d       = RegDst_i;
                err_d          = 1'b1;
            end
            OUT_BUBBLE: begin
                wb_d[REGWRITE] = 1'b0;
                wb_d[MEMTOREG] = 1'b0;
            end
            OUT_ABORT: begin
                wb_d[REGWRITE] = 1'b0;
                wb_d[MEMTOREG] = 1'b0;
                rdata_d        = '0;
                err_d          = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_q     <= '0;
            rdata_q  <= '0;
            alu_q    <= '0;
            regdst_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wb_q     <= wb_d;
            rdata_q  <= rdata_d;
            alu_q    <= alu_d;
            regdst_q <= regdst_d;
            err_q    <= err_d;
        end
    end

    assign WB_o        = wb_q;
    assign ReadData_o  = rdata_q;
    assign ALUresult_o = alu_q;
    assign RegDst_o    = regdst_q;
    assign err_o       = err_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: consumes the EX/MEM latch, runs one req/ack
// data-memory transaction at a time and stalls upstream while it is pending.
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int TO_CYC = 255,
    parameter int TO_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               WB_i,
    input  logic [1:0]               M_i,
    input  logic [DATA_W-1:0]        ALUresult_i,
    input  logic [DATA_W-1:0]        WriteData_i,
    input  logic [4:0]               RegDst_i,
    output logic                     stall_o,
    mem_stage_ctrl_if.master         mem_if,
    output logic [1:0]               WB_o,
    output logic [DATA_W-1:0]        ReadData_o,
    output logic [DATA_W-1:0]        ALUresult_o,
    output logic [4:0]               RegDst_o,
    output logic                     err_o
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TO_CYC - 1);

    state_t            state_d, state_q;
    logic              req_d,   req_q;
    logic              we_d,    we_q;
    logic [DATA_W-1:0] addr_d,  addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic [TO_W-1:0]   cnt_d,   cnt_q;

    logic              access;
    logic              illegal;
    logic              stall;
    out_op_t           out_op;
    logic [DATA_W-1:0] rdata_sel;

    assign access  = is_access(M_i);
    assign illegal = is_illegal(M_i, ALUresult_i[1:0]);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        out_op    = OUT_PASS;
        rdata_sel = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (illegal) begin
                    out_op = OUT_FAULT;
                end else if (access) begin
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = M_i[MEMWRITE];
                    addr_d  = ALUresult_i;
                    wdata_d = WriteData_i;
                    cnt_d   = '0;
                    out_op  = OUT_BUBBLE;
                end
            end
            ST_BUSY: begin
                // Ack takes priority over a timeout landing on the same cycle
                if (mem_if.mem_ack) begin
                    rdata_sel = we_q ? '0 : mem_if.mem_rdata;
                    req_d     = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    out_op  = OUT_ABORT;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    stall  = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    out_op = OUT_BUBBLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Upstream must not see a stall while the stage is being reset
    assign stall_o          = stall && !rst_i;
    assign mem_if.mem_req   = req_q;
    assign mem_if.mem_we    = we_q;
    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_wdata = wdata_q;

    mem_wb_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .op_i        (out_op),
        .WB_i        (WB_i),
        .ALUresult_i (ALUresult_i),
        .RegDst_i    (RegDst_i),
        .rdata_i     (rdata_sel),
        .WB_o        (WB_o),
        .ReadData_o  (ReadData_o),
        .ALUresult_o (ALUresult_o),
        .RegDst_o    (RegDst_o),
        .err_o       (err_o)
    );

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage access controller; the consuming end of the EX/MEM pipeline latch.
- Takes the WB/M control bits, ALU result (address), store data and destination register from EX/MEM. Runs a req/ack transaction to data memory and stalls the upstream pipeline while the access is outstanding.
- Presents a registered MEM/WB-side bundle (WB bits, read data, ALU result, dest reg).
- Inserts bubbles during stalls and aborts on timeout.

Parameters:
- DATA_W, 32, data and address width.
- TO_CYC, 255, BUSY cycles without ack before abort; must be ≥ 1.
- TO_W, 8, timeout counter width; must hold TO_CYC.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- WB_i  in  2  WB control from EX/MEM; [1]=RegWrite, [0]=MemtoReg
- M_i  in  2  MEM control from EX/MEM; [1]=MemRead, [0]=MemWrite
- ALUresult_i  in  DATA_W  address / ALU result
- WriteData_i  in  DATA_W  store data
- RegDst_i  in  5  destination register
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- mem_req_o  out  1  memory request (registered)
- mem_we_o  out  1  1 = write
- mem_addr_o  out  DATA_W  word-aligned address
- mem_wdata_o  out  DATA_W  store data
- mem_ack_i  in  1  one-cycle completion strobe
- mem_rdata_i  in  DATA_W  read data, valid with ack
- WB_o  out  2  to MEM/WB consumer
- ReadData_o  out  DATA_W  loaded data
- ALUresult_o  out  DATA_W  passed-through ALU result
- RegDst_o  out  5  passed-through dest reg
- err_o  out  1  one-cycle fault pulse

Behaviour:
- Reset: every output register is 0 and the FSM is in IDLE. mem_req_o drops immediately (async). The counter clears. A transaction in flight is abandoned.
- Definitions:
  - access = M_i[1] ^ M_i[0].
  - illegal = (M_i == 2'b11) or (access and ALUresult_i[1:0] != 0).
- FSM states: IDLE, BUSY.
- IDLE, no access, not illegal:
  - stall_o=0.
  - At the edge, the outputs load WB_i, ALUresult_i and RegDst_i, with ReadData_o=0.
  - Latency is 1 cycle.
- IDLE, illegal:
  - No request; stall_o=0.
  - At the edge, the outputs load with WB_o forced to 00, and err_o=1 for one cycle.
- IDLE, access and legal:
  - stall_o=1.
  - At the edge: go to BUSY; mem_req_o<=1; mem_we_o<=M_i[0]; mem_addr_o<=ALUresult_i; mem_wdata_o<=WriteData_i; counter<=0; WB_o<=00 (bubble).
- BUSY:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until the terminating edge.
  - The EX/MEM inputs are stable because stall is asserted.
  - stall_o = !mem_ack_i && counter != TO_CYC-1.
- BUSY, ack cycle:
  - stall_o=0.
  - At the edge: the outputs load WB_i, ALUresult_i and RegDst_i; ReadData_o<=mem_rdata_i for a read, or 0 for a write; mem_req_o<=0; go to IDLE.
- BUSY, no ack:
  - The counter increments.
- BUSY, counter==TO_CYC-1 without ack (timeout):
  - stall_o=0.
  - At the edge: WB_o<=00; ReadData_o<=0; mem_req_o<=0; err_o pulses; go to IDLE.
- Any BUSY edge without ack or timeout: WB_o<=00, giving one bubble per stall cycle.
- Ack and timeout on the same cycle: the ack wins.
- Ack while in IDLE: ignored.
- Back-to-back accesses: after ack the FSM returns to IDLE. mem_req_o is low for at least one cycle between transactions.
- err_o returns to 0 on the cycle after any pulse.

Decomposition:
- Shared package cpu_pkg:
  - WB/M bit-index constants (REGWRITE, MEMTOREG, MEMREAD, MEMWRITE).
  - FSM state enum.
  - DATA_W.
- Sub-module: none required. The output bundle register may be split out as mem_wb_out_reg if MEM_WB is later merged.

Test Plan:
- ALU op, M_i=00, WB_i=10, ALUresult_i=0x1234, RegDst_i=5 -> next edge: WB_o=10, ALUresult_o=0x1234, RegDst_o=5, stall_o never high, mem_req_o stays 0.
- Load, M_i=10, addr=0x40; responder acks after 3 cycles with 0xDEADBEEF -> stall_o high 3 cycles; mem_req_o high, mem_we_o=0, addr 0x40 stable; WB_o=00 during stall; after the ack edge ReadData_o=0xDEADBEEF, WB_o=WB_i, mem_req_o=0.
- Store, M_i=01, addr=0x80, WriteData_i=0xCAFE; ack on the first BUSY cycle -> mem_we_o=1, mem_wdata_o=0xCAFE; stall_o high 1 cycle; ReadData_o=0.
- Misaligned load, addr=0x42 -> no mem_req_o, err_o pulses 1 cycle, WB_o=00, no stall.
- Timeout with TO_CYC=4 and no ack -> stall_o high 4 cycles, then err_o pulse, mem_req_o=0, WB_o=00, FSM in IDLE.
- rst_i asserted in BUSY mid-transaction -> mem_req_o, stall_o and all outputs 0 immediately; after release, a new load completes normally.
